pattern_ctrl: RTL and testbench
===============================

# pattern_ctrl

Pattern-select controller that drives the 2-bit `state` input of the dot-matrix scanner. It debounces two push buttons and steps the displayed pattern through a fixed cycle. Patterns advance either manually on a "next" press or automatically on a timer. It sits between the board buttons and the dot-matrix row/column driver, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable samples required before a button level is accepted; must be ≥ 2.
- `AUTO_PERIOD`, default 50000000: clock cycles between automatic advances; must be ≥ 2.
- `clock` in 1: single system clock; all flops on its rising edge.
- `reset` in 1: asynchronous, active-low; `reset` = 0 clears all state immediately.
- `btn_next` in 1: raw "next pattern" button, active-high, asynchronous to `clock`.
- `btn_mode` in 1: raw "auto/manual toggle" button, active-high, asynchronous to `clock`.
- `state` out 2: pattern select to the dot-matrix driver.
- `auto_mode` out 1: 1 = timer-driven advance, 0 = manual.
- `advance` out 1: one-cycle pulse, high in the same cycle that `state` takes its new value.

## Operation
- Each button passes through its own 2-flop synchronizer, then its own debouncer.
- Debouncer: keeps an accepted level (reset 0) and a counter (reset 0).
  - When the synchronized sample differs from the accepted level, the counter increments.
  - When the synchronized sample equals the accepted level, the counter clears.
  - When the counter would reach `DEBOUNCE_CYCLES`, the accepted level flips and the counter clears.
- Press event: a one-cycle registered pulse issued in the cycle the accepted level flips 0→1. Release events produce nothing.
- Pattern FSM states and cycle: PAT0 (2'b00) → PAT1 (2'b01) → PAT2 (2'b10) → PAT0. The `state` output is the FSM register.
- Manual advance: a `btn_next` press event moves the FSM one step, in either mode.
- Mode toggle: a `btn_mode` press event inverts `auto_mode` and clears the auto timer.
- Auto timer: counts only while `auto_mode` = 1. On reaching `AUTO_PERIOD`-1 it issues an advance and wraps to 0. Any manual advance also clears it to 0.
- Simultaneous events:
  - Manual press and timer expiry in the same cycle: exactly one step.
  - Mode press and next press in the same cycle: both take effect (toggle plus one step), and the timer is cleared.
- Reset values: `state` = 2'b00, `auto_mode` = 0, `advance` = 0, all counters and accepted levels 0, synchronizers 0.
- Reset mid-debounce or mid-timer abandons progress. A button still held after reset release is re-debounced and produces a press event.

## Timing
- Button latency: the input goes high before edge 1 and is held.
  - Edge 2: synchronizer output is 1.
  - Edge 2+`DEBOUNCE_CYCLES`: press pulse is registered.
  - Edge 3+`DEBOUNCE_CYCLES`: `state` updates and `advance` = 1 for that cycle.
- Glitches: a glitch shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no event.
- Auto cadence: with no manual input, consecutive `advance` pulses are exactly `AUTO_PERIOD` cycles apart. The first pulse comes `AUTO_PERIOD` cycles after the mode-toggle cycle.
- `advance` never stays high for two consecutive cycles from a single press or expiry.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PATTERN_BLANK_EN` defined: the FSM gains a fourth state BLANK (2'b11), and the cycle becomes PAT0→PAT1→PAT2→BLANK→PAT0. The dot-matrix driver renders 2'b11 as all columns off.
- `PATTERN_BLANK_EN` undefined: three-state cycle only, and `state` never equals 2'b11.
- All other behaviour is identical in both builds.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `AUTO_PERIOD`=10.
- Reset: drive `reset`=0 mid-run with buttons idle. Required: `state`=00, `auto_mode`=0 and `advance`=0 immediately, without waiting for a clock edge.
- Manual step: hold `btn_next` high from edge 1.
  - Required: `state` 00→01 at edge 7, with `advance` high for that one cycle only.
  - Three further press/release pairs then give 10, 00, 01. With `PATTERN_BLANK_EN` defined they give 10, 11, 00.
- Bounce rejection: toggle `btn_next` 1/0 every 2 cycles for 20 cycles, then hold 0. Required: `state` unchanged and no `advance` pulse.
- Auto mode: press `btn_mode`. Required:
  - `auto_mode` goes to 1.
  - `advance` pulses every 10 cycles and `state` cycles 01, 10, 00.
  - A second `btn_mode` press returns `auto_mode` to 0 and advances stop.
- Collision: in auto mode, align a `btn_next` press event with the timer-expiry cycle. Required: a single step (00→01), and the next auto `advance` exactly 10 cycles later.
- Reset mid-debounce: hold `btn_next`, assert `reset` for 1 cycle at debounce count 2, keep holding. Required: `state` = 00 after reset, then advance to 01 exactly 7 edges after reset release.

Source files
------------

// File: rtl/pattern_ctrl.sv
// pattern_ctrl
//   Pattern-select controller for the dot-matrix scanner. Two raw push buttons
//   are synchronized and debounced. A "next" press steps the displayed pattern
//   once. A "mode" press toggles between manual stepping and timer-driven
//   stepping.
//
// Build option:
//   PATTERN_BLANK_EN - when defined, adds a fourth BLANK pattern (2'b11) to the
//                      cycle PAT0 -> PAT1 -> PAT2 -> BLANK -> PAT0.
//
// Ports:
//   clock     in  1  system clock, rising edge
//   reset     in  1  asynchronous, active-low reset
//   btn_next  in  1  raw "next pattern" button, active-high, asynchronous
//   btn_mode  in  1  raw "auto/manual toggle" button, active-high, asynchronous
//   state     out 2  pattern select to the dot-matrix driver (registered)
//   auto_mode out 1  1 = timer-driven advance, 0 = manual (registered)
//   advance   out 1  one-cycle pulse in the cycle state takes its new value
module pattern_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_mode,
  output logic [1:0] state,
  output logic       auto_mode,
  output logic       advance
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

`ifdef PATTERN_BLANK_EN
  typedef enum logic [1:0] {PAT0 = 2'b00, PAT1 = 2'b01, PAT2 = 2'b10, BLANK = 2'b11} pat_t;
`else
  typedef enum logic [1:0] {PAT0 = 2'b00, PAT1 = 2'b01, PAT2 = 2'b10} pat_t;
`endif

  // Successor pattern in the display cycle; unused encodings recover to PAT0.
  function automatic pat_t next_pattern(input pat_t cur);
    pat_t nxt;
    case (cur)
      PAT0:    nxt = PAT1;
      PAT1:    nxt = PAT2;
`ifdef PATTERN_BLANK_EN
      PAT2:    nxt = BLANK;
      BLANK:   nxt = PAT0;
`else
      PAT2:    nxt = PAT0;
`endif
      default: nxt = PAT0;
    endcase
    return nxt;
  endfunction

  logic [1:0] btn_raw_s;
  logic [1:0] press_s;   // bit 0 = next press event, bit 1 = mode press event

  assign btn_raw_s = {btn_mode, btn_next};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    logic            meta_r;
    logic            sync_r;
    logic            level_r;
    logic            press_r;
    logic [DB_W-1:0] cnt_r;

    // Synchronize the raw button, then accept a new level only after
    // DEBOUNCE_CYCLES consecutive differing samples; pulse on a 0->1 flip.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        meta_r  <= 1'b0;
        sync_r  <= 1'b0;
        level_r <= 1'b0;
        press_r <= 1'b0;
        cnt_r   <= {DB_W{1'b0}};
      end else begin
        meta_r <= btn_raw_s[gi];
        sync_r <= meta_r;
        if (sync_r != level_r) begin
          if (cnt_r == DB_LAST) begin
            level_r <= ~level_r;
            cnt_r   <= {DB_W{1'b0}};
            press_r <= ~level_r;  // only the rising flip is an event
          end else begin
            cnt_r   <= cnt_r + 1'b1;
            press_r <= 1'b0;
          end
        end else begin
          cnt_r   <= {DB_W{1'b0}};
          press_r <= 1'b0;
        end
      end
    end

    assign press_s[gi] = press_r;
  end

  pat_t            state_r, state_n;
  logic            auto_r, auto_n;
  logic            adv_r, adv_n;
  logic [AP_W-1:0] timer_r, timer_n;
  logic            expire_s;
  logic            step_s;

  // Pattern, mode, timer and advance-pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= PAT0;
      auto_r  <= 1'b0;
      adv_r   <= 1'b0;
      timer_r <= {AP_W{1'b0}};
    end else begin
      state_r <= state_n;
      auto_r  <= auto_n;
      adv_r   <= adv_n;
      timer_r <= timer_n;
    end
  end

  // Next-state logic: a next press and a timer expiry in the same cycle merge
  // into a single step; any step or mode toggle restarts the timer.
  always_comb begin
    state_n  = state_r;
    auto_n   = auto_r;
    adv_n    = 1'b0;
    timer_n  = timer_r;
    expire_s = auto_r && (timer_r == AP_LAST);
    step_s   = press_s[0] || expire_s;

    if (auto_r) begin
      timer_n = timer_r + 1'b1;
    end else begin
      timer_n = timer_r;
    end

    if (step_s) begin
      state_n = next_pattern(state_r);
      adv_n   = 1'b1;
      timer_n = {AP_W{1'b0}};
    end else begin
      state_n = state_r;
    end

    if (press_s[1]) begin
      auto_n  = ~auto_r;
      timer_n = {AP_W{1'b0}};
    end else begin
      auto_n = auto_r;
    end
  end

  assign state     = state_r;
  assign auto_mode = auto_r;
  assign advance   = adv_r;

endmodule

// File: tb/tb_pattern_ctrl.sv
// tb_pattern_ctrl
//   Directed-vector bench for pattern_ctrl with DEBOUNCE_CYCLES = 4 and
//   AUTO_PERIOD = 10. Inputs are driven 1 time unit after a rising edge and
//   outputs are sampled at the same point, so "after edge N" below means the
//   values registered at edge N.
module tb_pattern_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_next;
  logic       btn_mode;
  logic [1:0] state;
  logic       auto_mode;
  logic       advance;

  int         vectors     = 0;
  int         miscompares = 0;
  int         adv_count   = 0;
  int         adv_mark;
  logic [1:0] exp_state;

  pattern_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_next (btn_next),
    .btn_mode (btn_mode),
    .state    (state),
    .auto_mode(auto_mode),
    .advance  (advance)
  );

  always #5 clock = ~clock;

  // Count advance pulses mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (advance === 1'b1) begin
      adv_count = adv_count + 1;
    end
  end

  // Expected pattern cycle.
  function automatic logic [1:0] next_pat(input logic [1:0] s);
`ifdef PATTERN_BLANK_EN
    return s + 2'd1;
`else
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    btn_next = 1'b0;
    btn_mode = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_val("por_state", 32'(state), 32'h0);
    check_val("por_auto", 32'(auto_mode), 32'h0);
    check_val("por_adv", 32'(advance), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(2);
    exp_state = 2'b00;

    // Manual step: press held from edge 1, step lands at edge 7.
    btn_next = 1'b1;
    tick(6);
    check_val("man_e6_state", 32'(state), 32'h0);
    check_val("man_e6_adv", 32'(advance), 32'h0);
    tick(1);
    exp_state = next_pat(exp_state);
    check_val("man_e7_state", 32'(state), 32'(exp_state));
    check_val("man_e7_adv", 32'(advance), 32'h1);
    tick(1);
    check_val("man_e8_adv", 32'(advance), 32'h0);
    btn_next = 1'b0;
    tick(10);

    // Three further presses.
    for (int k = 0; k < 3; k++) begin
      btn_next = 1'b1;
      tick(6);
      check_val("man_pre_adv", 32'(advance), 32'h0);
      tick(1);
      exp_state = next_pat(exp_state);
      check_val("man_step_state", 32'(state), 32'(exp_state));
      check_val("man_step_adv", 32'(advance), 32'h1);
      if (k != 2) begin
        tick(1);
        check_val("man_post_adv", 32'(advance), 32'h0);
        btn_next = 1'b0;
        tick(10);
      end
    end

    // Reset mid-run, while advance is high: outputs clear without a clock edge.
    reset    = 1'b0;
    btn_next = 1'b0;
    #1;
    check_val("rst_state", 32'(state), 32'h0);
    check_val("rst_auto", 32'(auto_mode), 32'h0);
    check_val("rst_adv", 32'(advance), 32'h0);
    exp_state = 2'b00;
    tick(2);
    reset = 1'b1;
    tick(2);

    // Bounce rejection: 2-cycle high/low toggling never completes a debounce.
    adv_mark = adv_count;
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1;
      tick(2);
      btn_next = 1'b0;
      tick(2);
    end
    tick(10);
    check_val("bounce_state", 32'(state), 32'(exp_state));
    check_val("bounce_advs", 32'(adv_count), 32'(adv_mark));

    // Auto mode: toggle lands at edge 7 (call it M), advances at M+10, +20, +30.
    btn_mode = 1'b1;
    tick(6);
    check_val("mode_e6_auto", 32'(auto_mode), 32'h0);
    tick(1);
    check_val("mode_e7_auto", 32'(auto_mode), 32'h1);
    btn_mode = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick(9);
      check_val("auto_gap_adv", 32'(advance), 32'h0);
      tick(1);
      exp_state = next_pat(exp_state);
      check_val("auto_adv", 32'(advance), 32'h1);
      check_val("auto_state", 32'(state), 32'(exp_state));
    end

    // Collision: next press step lands on the M+40 expiry -> one step only.
    tick(3);
    btn_next = 1'b1;
    tick(6);
    check_val("coll_pre_adv", 32'(advance), 32'h0);
    check_val("coll_pre_state", 32'(state), 32'(exp_state));
    tick(1);
    exp_state = next_pat(exp_state);
    check_val("coll_state", 32'(state), 32'(exp_state));
    check_val("coll_adv", 32'(advance), 32'h1);
    btn_next = 1'b0;
    tick(1);
    check_val("coll_post_adv", 32'(advance), 32'h0);
    tick(8);
    check_val("coll_gap_adv", 32'(advance), 32'h0);
    tick(1);
    exp_state = next_pat(exp_state);
    check_val("coll_next_adv", 32'(advance), 32'h1);
    check_val("coll_next_state", 32'(state), 32'(exp_state));

    // Second mode press returns to manual; no further advances.
    btn_mode = 1'b1;
    tick(6);
    check_val("mode2_e6_auto", 32'(auto_mode), 32'h1);
    tick(1);
    check_val("mode2_e7_auto", 32'(auto_mode), 32'h0);
    btn_mode = 1'b0;
    adv_mark = adv_count;
    tick(25);
    check_val("manual_idle_advs", 32'(adv_count), 32'(adv_mark));
    check_val("manual_idle_state", 32'(state), 32'(exp_state));

    // Reset at debounce count 2 with the button still held.
    btn_next = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check_val("mid_rst_state", 32'(state), 32'h0);
    check_val("mid_rst_adv", 32'(advance), 32'h0);
    exp_state = 2'b00;
    tick(1);
    reset = 1'b1;
    tick(6);
    check_val("mid_e6_state", 32'(state), 32'h0);
    check_val("mid_e6_adv", 32'(advance), 32'h0);
    tick(1);
    exp_state = next_pat(exp_state);
    check_val("mid_e7_state", 32'(state), 32'(exp_state));
    check_val("mid_e7_adv", 32'(advance), 32'h1);
    btn_next = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
